// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives decode/execute status, consumes stall/flush/forward controls).
// slave:  controller side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regw;
    logic                  id_mem_r;
    logic                  id_jump;
    logic                  ex_branch_taken;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  redirect_en;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regw, id_mem_r, id_jump, ex_branch_taken,
        input  stall_f, stall_d, flush_d, flush_e, redirect_en,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regw, id_mem_r, id_jump, ex_branch_taken,
        output stall_f, stall_d, flush_d, flush_e, redirect_en,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: operand forwarding select, load-use stall, branch/jump flush, event counters.
// Latency: stall/flush/forward controls are combinational in the decode cycle; counters update at the edge.
// Backpressure: a load-use hazard holds fetch/decode for one cycle; a taken branch overrides any stall.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regw;
        logic                  mem_r;
    } shadow_t;

    state_t           state_q;
    shadow_t          ex_q;
    shadow_t          mem_q;
    shadow_t          wb_q;
    shadow_t          ex_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic use_a;
    logic use_b;
    logic ex_a;
    logic ex_b;
    logic mem_a;
    logic mem_b;
    logic wb_a;
    logic wb_b;
    logic load_use;
    logic branch;
    logic lu_stall;
    logic jump_ok;
    logic flush_evt;

    // r0 is hard-wired zero, so a writer of r0 must never be a forwarding source.
    function automatic logic src_match(input shadow_t s, input logic [REG_ADDR_W-1:0] src,
                                       input logic use_src);
        return use_src && s.valid && s.regw && (s.rd != '0) && (s.rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic e, input logic m, input logic w);
        if (e)      return 2'b01;
        else if (m) return 2'b10;
        else if (w) return 2'b11;
        else        return 2'b00;
    endfunction

    always_comb begin
        use_a     = hz.id_valid && hz.id_use_rs1;
        use_b     = hz.id_valid && hz.id_use_rs2;
        ex_a      = src_match(ex_q,  hz.id_rs1, use_a);
        ex_b      = src_match(ex_q,  hz.id_rs2, use_b);
        mem_a     = src_match(mem_q, hz.id_rs1, use_a);
        mem_b     = src_match(mem_q, hz.id_rs2, use_b);
        wb_a      = src_match(wb_q,  hz.id_rs1, use_a);
        wb_b      = src_match(wb_q,  hz.id_rs2, use_b);
        load_use  = hz.id_valid && ex_q.mem_r && (ex_a || ex_b);
        branch    = !rst && hz.ex_branch_taken;
        lu_stall  = !rst && (state_q == RUN) && load_use && !branch;
        // A jump blocked by a stall is simply re-evaluated when decode is re-presented.
        jump_ok   = !rst && (state_q != FLUSH) && hz.id_valid && hz.id_jump
                    && !lu_stall && !branch;
        flush_evt = branch || jump_ok;

        ex_d = '0;
        if (!lu_stall && !branch && (state_q != FLUSH)) begin
            ex_d.valid = hz.id_valid;
            ex_d.rd    = hz.id_rd;
            ex_d.regw  = hz.id_regw;
            ex_d.mem_r = hz.id_mem_r;
        end
    end

    assign hz.stall_f     = lu_stall;
    assign hz.stall_d     = lu_stall;
    assign hz.flush_d     = flush_evt;
    assign hz.flush_e     = lu_stall || branch;
    assign hz.redirect_en = !lu_stall;
    assign hz.fwd_a       = rst ? 2'b00 : fwd_sel(ex_a, mem_a, wb_a);
    assign hz.fwd_b       = rst ? 2'b00 : fwd_sel(ex_b, mem_b, wb_b);
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (branch)        state_q <= FLUSH;
            else if (lu_stall) state_q <= LU_STALL;
            else               state_q <= RUN;

            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;

            if (lu_stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_evt && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 id_valid  in  1  a real instruction occupies decode.
REQ-007 id_rs1, id_rs2  in  REG_ADDR_W  decode source indices.
REQ-008 id_use_rs1, id_use_rs2  in  1  decode instruction reads that source.
REQ-009 id_rd  in  REG_ADDR_W  decode destination index.
REQ-010 id_regw, id_mem_r  in  1  decode instruction writes a register / is a load.
REQ-011 id_jump  in  1  decode resolved an unconditional jump.
REQ-012 ex_branch_taken  in  1  execute resolved a taken branch.
REQ-013 stall_f, stall_d  out  1  hold PC / hold the fetch-decode register.
REQ-014 flush_d, flush_e  out  1  bubble the decode / execute pipeline register.
REQ-015 redirect_en  out  1  permit PC_Src redirect this cycle.
REQ-016 fwd_a, fwd_b  out  2  operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Function
REQ-018 Shadow tracking registers {valid, rd, regw, mem_r} for EX, MEM and WB shall be held; each edge: WB<=MEM, MEM<=EX.
REQ-019 EX shadow shall load the decode fields when no stall and no flush_e; otherwise it shall load valid=0.
REQ-020 A stage "matches" source s when stage valid, regw=1, rd!=0, rd==s, and the matching id_use_* is 1.
REQ-021 fwd_a/fwd_b shall be combinational: the EX match gives 01, else the MEM match 10, else the WB match 11, else 00; the nearest stage wins.
REQ-022 A load-use hazard exists when id_valid and the EX shadow has mem_r=1 and matches rs1 or rs2.
REQ-023 FSM states: RUN, LU_STALL, FLUSH.
REQ-024 RUN with a load-use hazard and no ex_branch_taken: same cycle stall_f=stall_d=1, flush_e=1, redirect_en=0; next state LU_STALL.
REQ-025 LU_STALL shall last exactly one cycle with all outputs deasserted except forwarding; the load is now in MEM; fwd_* shall select 10; next state RUN.
REQ-026 ex_branch_taken in any state: same cycle flush_d=flush_e=1, stall_*=0, redirect_en=1; next state FLUSH.
REQ-027 ex_branch_taken shall override a simultaneous load-use hazard; the dependent instruction is discarded and no stall shall be counted.
REQ-028 FLUSH shall last one cycle: EX shadow invalid, hazards ignored, stall/flush outputs 0; next state RUN.
REQ-029 id_jump in RUN without hazard: flush_d=1, redirect_en=1, state stays RUN.
REQ-030 id_jump coincident with load-use: the stall wins and redirect_en=0; the jump shall be re-evaluated when decode is re-presented.
REQ-031 redirect_en shall otherwise be 1 whenever stall_d=0.
REQ-032 stall_cnt shall increment once per REQ-024 entry.
REQ-033 flush_cnt shall increment once per ex_branch_taken or accepted id_jump cycle.
REQ-034 Both counters shall saturate at all-ones with no wrap.
REQ-035 id_valid=0 shall never raise a stall, flush or nonzero forward from decode sources.

Reset
REQ-036 rst high at an edge: state RUN; all shadows invalid with fields zero; counters 0; this applies mid-stall or mid-flush.
REQ-037 During and one cycle after reset: stall_f=stall_d=flush_d=flush_e=0, fwd_a=fwd_b=00, redirect_en=1.

Verification
REQ-038 Back-to-back ALU writes: a writer of r5 followed by a reader of rs1=5 -> fwd_a=01 in the reader's decode cycle; the next instruction reading r5 gets 10.
REQ-039 Load r7 then a reader of rs2=7 -> one cycle stall_f=stall_d=flush_e=1, then LU_STALL with fwd_b=10, then RUN; stall_cnt=1.
REQ-040 Load-use coincident with ex_branch_taken -> flush_d=flush_e=1, stall=0, FLUSH; flush_cnt=1 and stall_cnt=0.
REQ-041 id_jump with a load-use on the same cycle -> redirect_en=0 and stall; the next cycle id_jump gives flush_d=1 and redirect_en=1.
REQ-042 rst asserted in LU_STALL -> next cycle RUN, counters 0, fwd 00; a prior writer of r0 never forwards.
REQ-043 Force stall_cnt to all-ones minus 1, then apply two load-use events -> the count holds at all-ones.
